// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: work_type encodings, FSM states,
// requester identities and the IO address window marker.
package mem_arbiter_pkg;

    // Controller work_type encodings: bit2 = unsigned, [1:0] = size
    localparam logic [2:0] WT_B  = 3'b000;
    localparam logic [2:0] WT_H  = 3'b001;
    localparam logic [2:0] WT_W  = 3'b010;
    localparam logic [2:0] WT_BU = 3'b100;
    localparam logic [2:0] WT_HU = 3'b101;

    // addr[17:16] value that selects the memory-mapped IO window
    localparam logic [1:0] IO_HI = 2'b11;

    // Bit positions within the one-hot grant vector
    localparam int unsigned GNT_IF = 0;
    localparam int unsigned GNT_LS = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_LS = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
//   valid_if_i / valid_ls_i : eligible requesters this cycle
//   last_ls_i               : 1 when LS owned the previous grant
//   grant_c_o               : one-hot grant, bit GNT_IF or GNT_LS
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic       valid_if_i,
    input  logic       valid_ls_i,
    input  logic       last_ls_i,
    output logic [1:0] grant_c_o
);

    // On a tie the requester that did not win last time goes first
    always_comb begin
        grant_c_o = 2'b00;
        if (valid_if_i && valid_ls_i) begin
            if (last_ls_i) grant_c_o[GNT_IF] = 1'b1;
            else           grant_c_o[GNT_LS] = 1'b1;
        end else if (valid_if_i) begin
            grant_c_o[GNT_IF] = 1'b1;
        end else if (valid_ls_i) begin
            grant_c_o[GNT_LS] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the byte-serial memory controller between instruction fetch (IF)
// and the load/store buffer (LS). One task in flight at a time; the result is
// returned to its owner as a one-cycle done pulse.
//   clk_in, rst_in (async, active-high), rdy_in (global stall when low)
//   rob_clear      : flush; aborts in-flight reads, committed stores finish
//   io_buffer_full : holds IO-window stores back
//   if_* / ls_*    : requester handshakes (level req, pulsed done)
//   mc_*           : controller task interface
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter logic [1:0]  IO_HI  = mem_arbiter_pkg::IO_HI
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              rob_clear,
    input  logic              io_buffer_full,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,

    input  logic              ls_req,
    input  logic              ls_is_write,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    input  logic [2:0]        ls_work_type,
    output logic              ls_done,
    output logic [31:0]       ls_data,

    output logic              mc_new_task,
    output logic              mc_is_write,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [31:0]       mc_data_in,
    output logic [2:0]        mc_work_type,
    input  logic              mc_done,
    input  logic [31:0]       mc_data
);

    state_t              state_q;
    owner_t              last_grant_q;
    logic                if_done_q;
    logic [31:0]         if_data_q;
    logic                ls_done_q;
    logic [31:0]         ls_data_q;
    logic                mc_new_task_q;
    logic                mc_is_write_q;
    logic [ADDR_W-1:0]   mc_addr_q;
    logic [31:0]         mc_data_in_q;
    logic [2:0]          mc_work_type_q;

    logic                ls_io_hold_c;
    logic                if_cand_c;
    logic                ls_cand_c;
    logic [1:0]          grant_c;

    // IO stores wait while the UART buffer cannot take another byte
    assign ls_io_hold_c = ls_is_write && (ls_addr[17:16] == IO_HI) && io_buffer_full;

    // A requester still sees its own done pulse this cycle, so its req is stale
    assign if_cand_c = if_req && !if_done_q;
    assign ls_cand_c = ls_req && !ls_done_q && !ls_io_hold_c;

    rr_pick2 u_pick (
        .valid_if_i (if_cand_c),
        .valid_ls_i (ls_cand_c),
        .last_ls_i  (last_grant_q == OWNER_LS),
        .grant_c_o  (grant_c)
    );

    // Arbitration FSM with registered outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= IDLE;
            last_grant_q   <= OWNER_LS;
            if_done_q      <= 1'b0;
            if_data_q      <= '0;
            ls_done_q      <= 1'b0;
            ls_data_q      <= '0;
            mc_new_task_q  <= 1'b0;
            mc_is_write_q  <= 1'b0;
            mc_addr_q      <= '0;
            mc_data_in_q   <= '0;
            mc_work_type_q <= '0;
        end else if (rdy_in) begin
            if_done_q     <= 1'b0;
            ls_done_q     <= 1'b0;
            mc_new_task_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!rob_clear) begin
                        if (grant_c[GNT_IF]) begin
                            mc_new_task_q  <= 1'b1;
                            mc_is_write_q  <= 1'b0;
                            mc_addr_q      <= if_addr;
                            mc_data_in_q   <= '0;
                            mc_work_type_q <= WT_W;
                            last_grant_q   <= OWNER_IF;
                            state_q        <= BUSY_IF;
                        end else if (grant_c[GNT_LS]) begin
                            mc_new_task_q  <= 1'b1;
                            mc_is_write_q  <= ls_is_write;
                            mc_addr_q      <= ls_addr;
                            mc_data_in_q   <= ls_wdata;
                            mc_work_type_q <= ls_work_type;
                            last_grant_q   <= OWNER_LS;
                            state_q        <= BUSY_LS;
                        end
                    end
                end
                BUSY_IF: begin
                    if (rob_clear) begin
                        state_q <= IDLE;
                    end else if (mc_done) begin
                        if_data_q <= mc_data;
                        if_done_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                BUSY_LS: begin
                    // Stores are already committed and must not be dropped
                    if (rob_clear && !mc_is_write_q) begin
                        state_q <= IDLE;
                    end else if (mc_done) begin
                        ls_data_q <= mc_data;
                        ls_done_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_done      = if_done_q;
    assign if_data      = if_data_q;
    assign ls_done      = ls_done_q;
    assign ls_data      = ls_data_q;
    assign mc_new_task  = mc_new_task_q;
    assign mc_is_write  = mc_is_write_q;
    assign mc_addr      = mc_addr_q;
    assign mc_data_in   = mc_data_in_q;
    assign mc_work_type = mc_work_type_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter: one record per clock cycle
// holding the inputs applied before the edge and all outputs expected after it.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, rob_clear, io_buffer_full;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req, ls_is_write;
    logic [31:0] ls_addr, ls_wdata;
    logic [2:0]  ls_work_type;
    logic        ls_done;
    logic [31:0] ls_data;
    logic        mc_new_task, mc_is_write;
    logic [31:0] mc_addr, mc_data_in;
    logic [2:0]  mc_work_type;
    logic        mc_done;
    logic [31:0] mc_data;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    mem_arbiter #(.ADDR_W(32), .IO_HI(2'b11)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .rob_clear      (rob_clear),
        .io_buffer_full (io_buffer_full),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .ls_req         (ls_req),
        .ls_is_write    (ls_is_write),
        .ls_addr        (ls_addr),
        .ls_wdata       (ls_wdata),
        .ls_work_type   (ls_work_type),
        .ls_done        (ls_done),
        .ls_data        (ls_data),
        .mc_new_task    (mc_new_task),
        .mc_is_write    (mc_is_write),
        .mc_addr        (mc_addr),
        .mc_data_in     (mc_data_in),
        .mc_work_type   (mc_work_type),
        .mc_done        (mc_done),
        .mc_data        (mc_data)
    );

    typedef struct {
        logic        rst, rdy, rob, iof, ifr, lsr, lsw;
        logic [31:0] la, wd;
        logic [2:0]  lwt;
        logic        mcd;
        logic [31:0] mcdat;
        logic [134:0] exp;
    } vec_t;

    vec_t tv[$];

    function automatic logic [134:0] outs();
        return {if_done, if_data, ls_done, ls_data, mc_new_task, mc_is_write,
                mc_addr, mc_data_in, mc_work_type};
    endfunction

    // Inputs: rst rdy rob iof | ifr lsr lsw la wd lwt | mcd mcdat
    // Expected: if_done if_data | ls_done ls_data | new_task is_write addr data_in work_type
    function automatic void add(
        input logic [31:0] rst, rdy, rob, iof, ifr, lsr, lsw, la, wd, lwt, mcd, mcdat,
        input logic [31:0] eifd, eifdat, elsd, elsdat, enew, ewr, eaddr, edin, ewt);
        vec_t v;
        v.rst = 1'(rst); v.rdy = 1'(rdy); v.rob = 1'(rob); v.iof = 1'(iof);
        v.ifr = 1'(ifr); v.lsr = 1'(lsr); v.lsw = 1'(lsw);
        v.la = la; v.wd = wd; v.lwt = 3'(lwt); v.mcd = 1'(mcd); v.mcdat = mcdat;
        v.exp = {1'(eifd), eifdat, 1'(elsd), elsdat, 1'(enew), 1'(ewr), eaddr, edin, 3'(ewt)};
        tv.push_back(v);
    endfunction

    task automatic check(input string name, input logic [134:0] got, input logic [134:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        bit found;
        rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'h1000;
        ls_req = 1'b0; ls_is_write = 1'b0; ls_addr = '0; ls_wdata = '0; ls_work_type = '0;
        mc_done = 1'b0; mc_data = '0;

        // IF alone
        add(1,1,0,0, 0,0,0,0,0,0, 0,0,           0,0,           0,0, 0,0,0,0,0);
        add(0,1,0,0, 1,0,0,0,0,0, 0,0,           0,0,           0,0, 1,0,'h1000,0,2);
        add(0,1,0,0, 1,0,0,0,0,0, 0,0,           0,0,           0,0, 0,0,'h1000,0,2);
        add(0,1,0,0, 1,0,0,0,0,0, 1,'hDEADBEEF,  1,'hDEADBEEF,  0,0, 0,0,'h1000,0,2);
        add(0,1,0,0, 1,0,0,0,0,0, 0,0,           0,'hDEADBEEF,  0,0, 0,0,'h1000,0,2);
        add(0,1,0,0, 0,0,0,0,0,0, 0,0,           0,'hDEADBEEF,  0,0, 0,0,'h1000,0,2);

        // IF and LS together from reset, then ties in both directions
        add(1,1,0,0, 0,0,0,0,0,0,       0,0,          0,0,          0,0,          0,0,0,0,0);
        add(0,1,0,0, 1,1,0,'h2000,0,2,  0,0,          0,0,          0,0,          1,0,'h1000,0,2);
        add(0,1,0,0, 1,1,0,'h2000,0,2,  0,0,          0,0,          0,0,          0,0,'h1000,0,2);
        add(0,1,0,0, 1,1,0,'h2000,0,2,  1,'h11111111, 1,'h11111111, 0,0,          0,0,'h1000,0,2);
        add(0,1,0,0, 1,1,0,'h2000,0,2,  0,0,          0,'h11111111, 0,0,          1,0,'h2000,0,2);
        add(0,1,0,0, 1,1,0,'h2000,0,2,  0,0,          0,'h11111111, 0,0,          0,0,'h2000,0,2);
        add(0,1,0,0, 1,1,0,'h2000,0,2,  1,'h22222222, 0,'h11111111, 1,'h22222222, 0,0,'h2000,0,2);
        add(0,1,0,0, 0,0,0,0,0,0,       0,0,          0,'h11111111, 0,'h22222222, 0,0,'h2000,0,2);
        add(0,1,0,0, 1,1,0,'h2000,0,2,  0,0,          0,'h11111111, 0,'h22222222, 1,0,'h1000,0,2);
        add(0,1,0,0, 1,1,0,'h2000,0,2,  1,'h33333333, 1,'h33333333, 0,'h22222222, 0,0,'h1000,0,2);
        add(0,1,0,0, 0,0,0,0,0,0,       0,0,          0,'h33333333, 0,'h22222222, 0,0,'h1000,0,2);
        add(0,1,0,0, 1,1,0,'h2000,0,2,  0,0,          0,'h33333333, 0,'h22222222, 1,0,'h2000,0,2);
        add(0,1,0,0, 1,1,0,'h2000,0,2,  1,'h44444444, 0,'h33333333, 1,'h44444444, 0,0,'h2000,0,2);
        add(0,1,0,0, 0,0,0,0,0,0,       0,0,          0,'h33333333, 0,'h44444444, 0,0,'h2000,0,2);

        // IO store held while the buffer is full
        add(1,1,0,0, 0,0,0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0);
        for (int i = 0; i < 5; i++)
            add(0,1,0,1, 0,1,1,'h30000,'h41,0, 0,0, 0,0,0,0, 0,0,0,0,0);
        add(0,1,0,0, 0,1,1,'h30000,'h41,0, 0,0,          0,0,          0,0,     1,1,'h30000,'h41,0);
        add(0,1,0,0, 0,1,1,'h30000,'h41,0, 1,0,          0,0,          1,0,     0,1,'h30000,'h41,0);
        add(0,1,0,0, 0,0,0,0,0,0,          0,0,          0,0,          0,0,     0,1,'h30000,'h41,0);
        add(0,1,0,0, 1,0,0,0,0,0,          0,0,          0,0,          0,0,     1,0,'h1000,0,2);
        add(0,1,0,0, 1,0,0,0,0,0,          1,'hAAAA0000, 1,'hAAAA0000, 0,0,     0,0,'h1000,0,2);
        add(0,1,0,0, 0,0,0,0,0,0,          0,0,          0,'hAAAA0000, 0,0,     0,0,'h1000,0,2);
        add(0,1,0,1, 1,1,1,'h30000,'h41,0, 0,0,          0,'hAAAA0000, 0,0,     1,0,'h1000,0,2);
        add(0,1,0,1, 1,1,1,'h30000,'h41,0, 1,'hBBBB0000, 1,'hBBBB0000, 0,0,     0,0,'h1000,0,2);
        add(0,1,0,1, 0,1,1,'h30000,'h41,0, 0,0,          0,'hBBBB0000, 0,0,     0,0,'h1000,0,2);
        add(0,1,0,0, 0,1,1,'h30000,'h41,0, 0,0,          0,'hBBBB0000, 0,0,     1,1,'h30000,'h41,0);
        add(0,1,0,0, 0,1,1,'h30000,'h41,0, 1,'h99,       0,'hBBBB0000, 1,'h99,  0,1,'h30000,'h41,0);
        add(0,1,0,0, 0,0,0,0,0,0,          0,0,          0,'hBBBB0000, 0,'h99,  0,1,'h30000,'h41,0);

        // rob_clear: aborts IF and LS loads, not stores; mc_done in IDLE ignored
        add(1,1,0,0, 0,0,0,0,0,0,                0,0,          0,0,          0,0, 0,0,0,0,0);
        add(0,1,0,0, 1,0,0,0,0,0,                0,0,          0,0,          0,0, 1,0,'h1000,0,2);
        add(0,1,1,0, 1,0,0,0,0,0,                0,0,          0,0,          0,0, 0,0,'h1000,0,2);
        add(0,1,0,0, 0,0,0,0,0,0,                1,'h5555,     0,0,          0,0, 0,0,'h1000,0,2);
        add(0,1,1,0, 1,0,0,0,0,0,                0,0,          0,0,          0,0, 0,0,'h1000,0,2);
        add(0,1,0,0, 1,0,0,0,0,0,                0,0,          0,0,          0,0, 1,0,'h1000,0,2);
        add(0,1,0,0, 1,0,0,0,0,0,                1,'h66666666, 1,'h66666666, 0,0, 0,0,'h1000,0,2);
        add(0,1,0,1, 0,1,1,'h100,'h12345678,2,   0,0,          0,'h66666666, 0,0, 1,1,'h100,'h12345678,2);
        add(0,1,1,1, 0,1,1,'h100,'h12345678,2,   0,0,          0,'h66666666, 0,0, 0,1,'h100,'h12345678,2);
        add(0,1,0,1, 0,1,1,'h100,'h12345678,2,   1,0,          0,'h66666666, 1,0, 0,1,'h100,'h12345678,2);
        add(0,1,0,0, 0,0,0,0,0,0,                0,0,          0,'h66666666, 0,0, 0,1,'h100,'h12345678,2);
        add(0,1,0,0, 0,1,0,'h2000,0,4,           0,0,          0,'h66666666, 0,0, 1,0,'h2000,0,4);
        add(0,1,1,0, 0,1,0,'h2000,0,4,           0,0,          0,'h66666666, 0,0, 0,0,'h2000,0,4);
        add(0,1,0,0, 0,0,0,0,0,0,                1,'h77,       0,'h66666666, 0,0, 0,0,'h2000,0,4);

        // rdy_in low mid-BUSY_LS swallows mc_done and freezes outputs
        add(1,1,0,0, 0,0,0,0,0,0,       0,0,          0,0, 0,0,          0,0,0,0,0);
        add(0,1,0,0, 0,1,0,'h2000,0,1,  0,0,          0,0, 0,0,          1,0,'h2000,0,1);
        add(0,0,0,0, 0,1,0,'h2000,0,1,  0,0,          0,0, 0,0,          1,0,'h2000,0,1);
        add(0,0,0,0, 0,1,0,'h2000,0,1,  1,'h77777777, 0,0, 0,0,          1,0,'h2000,0,1);
        add(0,0,0,0, 0,1,0,'h2000,0,1,  0,0,          0,0, 0,0,          1,0,'h2000,0,1);
        add(0,1,0,0, 0,1,0,'h2000,0,1,  0,0,          0,0, 0,0,          0,0,'h2000,0,1);
        add(0,1,0,0, 0,1,0,'h2000,0,1,  1,'h88888888, 0,0, 1,'h88888888, 0,0,'h2000,0,1);
        add(0,1,0,0, 0,0,0,0,0,0,       0,0,          0,0, 0,'h88888888, 0,0,'h2000,0,1);

        foreach (tv[i]) begin
            rst_in = tv[i].rst; rdy_in = tv[i].rdy; rob_clear = tv[i].rob;
            io_buffer_full = tv[i].iof; if_req = tv[i].ifr;
            ls_req = tv[i].lsr; ls_is_write = tv[i].lsw; ls_addr = tv[i].la;
            ls_wdata = tv[i].wd; ls_work_type = tv[i].lwt;
            mc_done = tv[i].mcd; mc_data = tv[i].mcdat;
            @(posedge clk_in);
            #1;
            check($sformatf("vec%0d", i), outs(), tv[i].exp);
        end

        // Asynchronous reset in the middle of a task
        rst_in = 1'b0; rdy_in = 1'b1; rob_clear = 1'b0; io_buffer_full = 1'b0;
        ls_req = 1'b0; mc_done = 1'b0; if_req = 1'b1; if_addr = 32'h1000;
        found = 1'b0;
        for (int c = 0; c < 5 && !found; c++) begin
            @(posedge clk_in);
            #1;
            if (mc_new_task) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL grant_timeout: got no mc_new_task expected one within 5 cycles");
        end
        check("pre_reset", outs(), {1'b0, 32'h0, 1'b0, 32'h88888888, 1'b1, 1'b0,
                                     32'h1000, 32'h0, 3'b010});
        #3;
        rst_in = 1'b1;
        #1;
        check("async_reset", outs(), 135'd0);
        if_req = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check("reset_hold", outs(), 135'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1);
    end

endmodule
